// File: rtl/dac_spi_tx_pkg.sv
// Shared types and constants for the DAC SPI transmitter.
//   state_e    : transmitter FSM states
//   CMD_NORMAL : two command bits that open each frame (normal operation)
//   OFFSET_XOR : mask that turns a 12-bit two's complement sample into offset binary
package dac_spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic [1:0]  CMD_NORMAL = 2'b00;
  localparam logic [11:0] OFFSET_XOR = 12'h800;

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample input and DAC pin bundle of the DAC SPI transmitter.
//   master : sample source side (drives en/f_s/din, observes pins and status)
//   slave  : transmitter side
//   en, f_s, din          : sample enable, sample strobe, signed sample
//   dac_sclk/cs_n/mosi    : SPI pins to the DAC
//   busy, frame_done, overrun : status
interface dac_spi_tx_if #(
  parameter int DATA_W = 12
);
  logic              en;
  logic              f_s;
  logic [DATA_W-1:0] din;
  logic              dac_sclk;
  logic              dac_cs_n;
  logic              dac_mosi;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  modport master (
    output en, f_s, din,
    input  dac_sclk, dac_cs_n, dac_mosi, busy, frame_done, overrun
  );

  modport slave (
    input  en, f_s, din,
    output dac_sclk, dac_cs_n, dac_mosi, busy, frame_done, overrun
  );
endinterface

// File: rtl/dac_spi_tx_sample_fifo.sv
// Synchronous sample FIFO, DATA_W x DEPTH, with show-ahead read.
//   clk, rst         : clock, asynchronous active-high reset (empties the FIFO)
//   push_i, din_i    : write request and data (caller must not push when full unless popping)
//   pop_i            : read request, dout_o is the head entry before the edge
//   full_o, empty_o  : occupancy flags
module dac_spi_tx_sample_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + PTR_ONE;
    if (pop_i)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // A push into a full FIFO with a simultaneous pop overwrites the slot being
  // popped, whose data has already been consumed this cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/dac_spi_tx.sv
// Serial transmitter from the filter-core output to a 12-bit SPI DAC.
// Buffers strobed samples, converts each to DAC code when popped and sends it
// as one {cmd, code, 2'b00} frame, MSB first, all pins registered.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.en/f_s/din                  : sample input (push on en && f_s)
//   bus.dac_sclk/dac_cs_n/dac_mosi  : SPI pins, sclk idles high
//   bus.busy/frame_done/overrun     : status, overrun is sticky until rst
//
// state | meaning
// IDLE  | waiting for a buffered sample; pops and loads the shift register
// SETUP | cs_n low, sclk high, first bit on mosi for CLK_DIV cycles
// SHIFT | per bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles
// HOLD  | cs_n low, sclk high for CLK_DIV cycles after the last bit
// GAP   | cs_n high for GAP_CYC cycles, frame_done in the first one
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 12,
  parameter int FRAME_W    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 2,
  parameter bit OFFSET_BIN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  dac_spi_tx_if.slave bus
);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [BIT_W-1:0] BIT_ONE = 1;
  localparam logic [BIT_W-1:0] BIT_LST = BIT_W'(FRAME_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                phase_q, phase_d;    // 0: sclk low half, 1: sclk high half
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic                cs_n_q, sclk_q, mosi_q, busy_q, frame_done_q, overrun_q;
  logic                cs_n_d, sclk_d, mosi_d;

  logic                push_req, push, pop, drop, tc;
  logic                fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_dout;
  logic [DATA_W-1:0]   code;
  logic [FRAME_W-1:0]  frame;

  assign push_req = bus.en && bus.f_s;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  dac_spi_tx_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign code  = OFFSET_BIN ? (fifo_dout ^ OFFSET_XOR) : fifo_dout;
  assign frame = FRAME_W'({CMD_NORMAL, code, 2'b00});
  assign tc    = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = frame;
          cnt_d   = CNT_DIV;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tc) begin
          state_d = SHIFT;
          phase_d = 1'b0;
          bit_d   = '0;
          cnt_d   = CNT_DIV;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SHIFT: begin
        if (!tc) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!phase_q) begin
          // sclk rises: the DAC has taken this bit, present the next one
          phase_d = 1'b1;
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          cnt_d   = CNT_DIV;
        end else if (bit_q == BIT_LST) begin
          state_d = HOLD;
          cnt_d   = CNT_DIV;
        end else begin
          phase_d = 1'b0;
          bit_d   = bit_q + BIT_ONE;
          cnt_d   = CNT_DIV;
        end
      end
      HOLD: begin
        if (tc) begin
          state_d = GAP;
          cnt_d   = CNT_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (tc) state_d = IDLE;
        else    cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they line up with it.
    cs_n_d = (state_d == IDLE) || (state_d == GAP);
    sclk_d = !((state_d == SHIFT) && !phase_d);
    mosi_d = cs_n_d ? 1'b0 : shreg_d[FRAME_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      shreg_q      <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      shreg_q      <= shreg_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      // Staying in IDLE implies no pop, so the FIFO is non-empty next cycle
      // exactly when it is non-empty now or a push lands.
      busy_q       <= (state_d != IDLE) || !fifo_empty || push;
      frame_done_q <= (state_q == HOLD) && (state_d == GAP);
      overrun_q    <= overrun_q | drop;
    end
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_mosi   = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: one offset-binary instance and one two's complement
// instance, a pin-level frame monitor and a reference frame function.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_spi_tx_if #(.DATA_W(12)) bus0 ();
  dac_spi_tx_if #(.DATA_W(12)) bus1 ();

  dac_spi_tx #(.OFFSET_BIN(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dac_spi_tx #(.OFFSET_BIN(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    int          low;
    int          falls;
    int          start;
  } ev_t;
  ev_t ev_q[$];

  logic        cs_a   [2];
  logic        sclk_a [2];
  logic        mosi_a [2];
  logic        fd_a   [2];
  assign cs_a[0] = bus0.dac_cs_n;   assign cs_a[1] = bus1.dac_cs_n;
  assign sclk_a[0] = bus0.dac_sclk; assign sclk_a[1] = bus1.dac_sclk;
  assign mosi_a[0] = bus0.dac_mosi; assign mosi_a[1] = bus1.dac_mosi;
  assign fd_a[0] = bus0.frame_done; assign fd_a[1] = bus1.frame_done;

  int          cyc = 0;
  int          nfall    [2] = '{0, 0};
  int          lowcnt   [2] = '{0, 0};
  int          cs_falls [2] = '{0, 0};
  int          fd_cnt   [2] = '{0, 0};
  int          start_c  [2] = '{0, 0};
  int          mosi_viol = 0;
  logic        prev_cs   [2] = '{1'b1, 1'b1};
  logic        prev_sclk [2] = '{1'b1, 1'b1};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  logic        in_fr     [2] = '{1'b0, 1'b0};
  logic [15:0] bits      [2] = '{16'h0, 16'h0};

  // Pin monitor: rebuilds frames from the SPI pins as the DAC would see them.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        in_fr[k]     = 1'b0;
        prev_cs[k]   = 1'b1;
        prev_sclk[k] = 1'b1;
        prev_mosi[k] = 1'b0;
      end else begin
        if (prev_cs[k] && !cs_a[k]) begin
          in_fr[k]   = 1'b1;
          bits[k]    = 16'h0;
          nfall[k]   = 0;
          lowcnt[k]  = 0;
          start_c[k] = cyc;
          cs_falls[k]++;
        end
        if (!cs_a[k]) begin
          lowcnt[k]++;
          if (prev_sclk[k] && !sclk_a[k]) begin
            bits[k] = {bits[k][14:0], mosi_a[k]};
            nfall[k]++;
          end
          if (!prev_sclk[k] && !sclk_a[k] && (mosi_a[k] != prev_mosi[k])) mosi_viol++;
        end
        if (!prev_cs[k] && cs_a[k] && in_fr[k]) begin
          ev_q.push_back('{k, bits[k], lowcnt[k], nfall[k], start_c[k]});
          in_fr[k] = 1'b0;
        end
        if (fd_a[k]) fd_cnt[k]++;
        prev_cs[k]   = cs_a[k];
        prev_sclk[k] = sclk_a[k];
        prev_mosi[k] = mosi_a[k];
      end
    end
  end

  // Reference: DAC code is the sample plus mid-scale (offset binary) or the
  // sample modulo 4096 (two's complement), placed above two zero pad bits.
  function automatic logic [15:0] ref_frame(int d, bit ob);
    int c;
    c = ob ? (d + 2048) : (d & 4095);
    return 16'(c * 4);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(int n, int budget, string tag);
    int i = 0;
    while (ev_q.size() < n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check({tag, "_arrived"}, 32'(ev_q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(string tag, int inst, logic [15:0] exp);
    ev_t e;
    if (ev_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no frame expected %0h", tag, exp);
    end else begin
      e = ev_q.pop_front();
      check({tag, "_inst"}, e.inst, inst);
      check({tag, "_frame"}, {16'h0, e.frame}, {16'h0, exp});
      check({tag, "_cs_low"}, e.low, 136);
      check({tag, "_falls"}, e.falls, 16);
    end
  endtask

  task automatic pulse(int k, logic [11:0] d);
    @(posedge clk); #1;
    if (k == 0) begin bus0.f_s = 1'b1; bus0.din = d; end
    else        begin bus1.f_s = 1'b1; bus1.din = d; end
    @(posedge clk); #1;
    bus0.f_s = 1'b0;
    bus1.f_s = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sd;
    int   saved;
    int   st[5];
    int   i;
    logic [15:0] exp_q[$];

    bus0.en = 1'b1; bus0.f_s = 1'b0; bus0.din = '0;
    bus1.en = 1'b1; bus1.f_s = 1'b0; bus1.din = '0;

    repeat (3) @(negedge clk);
    check("rst_cs_n", bus0.dac_cs_n, 1);
    check("rst_sclk", bus0.dac_sclk, 1);
    check("rst_mosi", bus0.dac_mosi, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_frame_done", bus0.frame_done, 0);
    check("rst_overrun", bus0.overrun, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Latency and basic frame for din=0
    @(posedge clk); #1 bus0.din = 12'h000; bus0.f_s = 1'b1;
    @(posedge clk); #1 bus0.f_s = 1'b0;
    check("lat_cs_still_high", bus0.dac_cs_n, 1);
    check("lat_busy", bus0.busy, 1);
    @(posedge clk); #1;
    check("lat_cs_low", bus0.dac_cs_n, 0);
    wait_frames(1, 400, "t1");
    check_frame("t1", 0, ref_frame(0, 1'b1));
    repeat (10) @(negedge clk);
    check("t1_frame_done_once", fd_cnt[0], 1);
    check("t1_busy_idle", bus0.busy, 0);

    // Offset binary extremes
    pulse(0, 12'h800);
    wait_frames(1, 400, "t2a");
    check_frame("t2_min", 0, ref_frame(-2048, 1'b1));
    pulse(0, 12'h7FF);
    wait_frames(1, 400, "t2b");
    check_frame("t2_max", 0, ref_frame(2047, 1'b1));

    // Two's complement instance
    pulse(1, 12'hFFF);
    wait_frames(1, 400, "t3a");
    check_frame("t3_m1", 1, ref_frame(-1, 1'b0));
    pulse(1, 12'h800);
    wait_frames(1, 400, "t3b");
    check_frame("t3_min", 1, ref_frame(-2048, 1'b0));
    repeat (10) @(negedge clk);

    // Disabled: strobes ignored
    saved = cs_falls[0];
    bus0.en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      pulse(0, 12'(j + 100));
      check("t5_busy_during", bus0.busy, 0);
    end
    repeat (50) @(negedge clk);
    check("t5_no_frame", cs_falls[0], saved);
    check("t5_cs_high", bus0.dac_cs_n, 1);
    check("t5_busy", bus0.busy, 0);
    check("t5_overrun", bus0.overrun, 0);
    bus0.en = 1'b1;

    // Random samples at spacings the buffer always absorbs
    for (int j = 0; j < 8; j++) begin
      sd = int'($urandom_range(0, 4095)) - 2048;
      pulse(0, sd[11:0]);
      exp_q.push_back(ref_frame(sd, 1'b1));
      repeat ($urandom_range(100, 200)) @(posedge clk);
    end
    wait_frames(8, 3000, "rnd");
    i = 0;
    while (exp_q.size() > 0) begin
      check_frame($sformatf("rnd%0d", i), 0, exp_q.pop_front());
      i++;
    end
    check("rnd_overrun", bus0.overrun, 0);
    repeat (10) @(negedge clk);

    // Six back-to-back strobes: five fit, the sixth is dropped
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1 bus0.f_s = 1'b1; bus0.din = 12'(j);
    end
    @(posedge clk); #1 bus0.f_s = 1'b0;
    wait_frames(5, 1200, "t4");
    check("t4_busy_in_gap", bus0.busy, 1);
    for (int j = 0; j < 5; j++) begin
      if (ev_q.size() > j) st[j] = ev_q[j].start;
      else st[j] = 0;
    end
    for (int j = 1; j < 5; j++) check($sformatf("t4_spacing%0d", j), st[j] - st[j-1], 139);
    for (int j = 1; j <= 5; j++) check_frame($sformatf("t4_s%0d", j), 0, ref_frame(j, 1'b1));
    @(negedge clk);
    check("t4_busy_gap_end", bus0.busy, 1);
    @(negedge clk);
    check("t4_busy_fall", bus0.busy, 0);
    check("t4_overrun", bus0.overrun, 1);
    repeat (200) @(negedge clk);
    check("t4_no_sixth", ev_q.size(), 0);

    // Async reset in the middle of the shift phase
    pulse(0, 12'h123);
    i = 0;
    while (!(nfall[0] >= 7 && !bus0.dac_cs_n) && i < 500) begin
      @(negedge clk); #1;
      i++;
    end
    check("t6_reached_shift", 32'(nfall[0] >= 7), 1);
    check("t6_cs_low_before", bus0.dac_cs_n, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_cs_async", bus0.dac_cs_n, 1);
    check("t6_sclk_async", bus0.dac_sclk, 1);
    check("t6_busy_async", bus0.busy, 0);
    check("t6_overrun_cleared", bus0.overrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    saved = cs_falls[0];
    repeat (300) @(negedge clk);
    check("t6_no_frame", cs_falls[0], saved);
    check("t6_no_event", ev_q.size(), 0);
    check("t6_busy_idle", bus0.busy, 0);
    pulse(0, 12'hFFB);
    wait_frames(1, 400, "t6");
    check_frame("t6_post", 0, ref_frame(-5, 1'b1));

    check("mosi_stable_low", mosi_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
